// File: rtl/run_monitor_pkg.sv
// ============================================================================
// Module  : run_monitor_pkg
// Brief   : Shared types and default addresses for the CPU run monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package run_monitor_pkg;

  // Default MIPS boot vector and the fetch address that marks program end.
  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    RUN        = 2'd1,
    DONE       = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_V0      = 2'd1,
    FAIL_TIMEOUT = 2'd2,
    FAIL_START   = 2'd3
  } fail_e;

endpackage

`default_nettype wire

// File: rtl/run_monitor_trace_buf.sv
// ============================================================================
// Module  : run_monitor_trace_buf
// Brief   : Circular buffer of redirect targets; index 0 reads the newest
//           entry, with a registered (1-cycle) read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module run_monitor_trace_buf #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [31:0]      rdata_o
);

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] wptr_q;
  logic [31:0]      rdata_q;
  logic [IDX_W-1:0] rd_ptr;

  // Newest entry sits just behind the write pointer; DEPTH is a power of two
  // so the subtraction wraps naturally.
  always_comb begin
    rd_ptr = wptr_q - IDX_W'(1) - idx_i;
  end

  // Storage, write pointer and registered read; cleared entries read as 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[rd_ptr];
      if (wr_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + IDX_W'(1);
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/cpu_run_monitor.sv
// ============================================================================
// Module  : cpu_run_monitor
// Brief   : Watches the CPU fetch stream, detects halt / timeout / bad start,
//           counts fetches and redirects, and latches a single verdict.
//           Optional redirect trace enabled by macro RUN_MONITOR_TRACE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_monitor
  import run_monitor_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR,
  parameter int          CNT_W        = 16,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  input  logic                           active,
  input  logic [31:0]                    instr_address,
  input  logic [31:0]                    register_v0,
  input  logic [31:0]                    expected_v0,
  input  logic [CNT_W-1:0]               max_cycles,
  output logic                           done,
  output logic                           pass,
  output logic [1:0]                     fail_code,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               fetch_count,
  output logic [CNT_W-1:0]               redirect_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [31:0]                    trace_addr
);

  state_e           state_q, state_d;
  fail_e            fail_q, fail_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] redir_q, redir_d;
  logic [31:0]      prev_pc_q, prev_pc_d;
  logic             halt_hit;
  logic             timeout_hit;
  logic             redirect_hit;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Termination conditions; the timeout compare is one bit wider so that
  // cycle_count+1 can never wrap onto a small limit.
  always_comb begin
    halt_hit    = (instr_address == HALT_ADDR) || !active;
    timeout_hit = (max_cycles != '0) &&
                  (({1'b0, cyc_q} + (CNT_W+1)'(1)) == {1'b0, max_cycles});
  end

  // Next-state, verdict and counter updates; everything holds unless enabled.
  always_comb begin
    state_d      = state_q;
    fail_d       = fail_q;
    done_d       = done_q;
    pass_d       = pass_q;
    cyc_d        = cyc_q;
    fetch_d      = fetch_q;
    redir_d      = redir_q;
    prev_pc_d    = prev_pc_q;
    redirect_hit = 1'b0;
    if (clk_enable) begin
      case (state_q)
        WAIT_START: begin
          if (instr_address == RESET_VECTOR) begin
            state_d   = RUN;
            prev_pc_d = instr_address;
            fetch_d   = CNT_W'(1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            fail_d  = FAIL_START;
          end
        end
        RUN: begin
          if (halt_hit) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (register_v0 == expected_v0);
            fail_d  = (register_v0 == expected_v0) ? FAIL_NONE : FAIL_V0;
          end else if (timeout_hit) begin
            state_d = DONE;
            done_d  = 1'b1;
            fail_d  = FAIL_TIMEOUT;
          end else begin
            cyc_d     = sat_inc(cyc_q);
            prev_pc_d = instr_address;
            if (instr_address != prev_pc_q) begin
              fetch_d = sat_inc(fetch_q);
              if (instr_address != (prev_pc_q + 32'd4)) begin
                redir_d      = sat_inc(redir_q);
                redirect_hit = 1'b1;
              end
            end
          end
        end
        default: begin
          // DONE: verdict and counters frozen until reset.
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_START;
      fail_q    <= FAIL_NONE;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      cyc_q     <= '0;
      fetch_q   <= '0;
      redir_q   <= '0;
      prev_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      cyc_q     <= cyc_d;
      fetch_q   <= fetch_d;
      redir_q   <= redir_d;
      prev_pc_q <= prev_pc_d;
    end
  end

  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_code      = fail_q;
  assign cycle_count    = cyc_q;
  assign fetch_count    = fetch_q;
  assign redirect_count = redir_q;

`ifdef RUN_MONITOR_TRACE_EN
  run_monitor_trace_buf #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk     (clk),
    .reset   (reset),
    .en_i    (clk_enable),
    .wr_i    (redirect_hit),
    .wdata_i (instr_address),
    .idx_i   (trace_idx),
    .rdata_o (trace_addr)
  );
`else
  logic trace_unused;
  assign trace_unused = ^{trace_idx, redirect_hit};
  assign trace_addr   = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
// ============================================================================
// Module  : tb_cpu_run_monitor
// Brief   : Self-checking bench for cpu_run_monitor: directed programs plus
//           randomized fetch streams against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_monitor;

  localparam int          CNT_W  = 6;
  localparam int          TDEPTH = 4;
  localparam logic [31:0] RV     = 32'hBFC0_0000;
  localparam logic [31:0] HALT   = 32'h0000_0000;
  localparam int          SATMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clk_enable = 1'b0;
  logic             active = 1'b1;
  logic [31:0]      instr_address = 32'd0;
  logic [31:0]      register_v0 = 32'd0;
  logic [31:0]      expected_v0 = 32'd0;
  logic [CNT_W-1:0] max_cycles = '0;
  logic [1:0]       trace_idx = 2'd0;
  logic             done, pass;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] cycle_count, fetch_count, redirect_count;
  logic [31:0]      trace_addr;

  cpu_run_monitor #(
    .RESET_VECTOR (RV),
    .HALT_ADDR    (HALT),
    .CNT_W        (CNT_W),
    .TRACE_DEPTH  (TDEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .instr_address  (instr_address),
    .register_v0    (register_v0),
    .expected_v0    (expected_v0),
    .max_cycles     (max_cycles),
    .done           (done),
    .pass           (pass),
    .fail_code      (fail_code),
    .cycle_count    (cycle_count),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count),
    .trace_idx      (trace_idx),
    .trace_addr     (trace_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_started, m_finished;
  int          m_done, m_pass, m_fc, m_cyc, m_fetch, m_redir;
  logic [31:0] m_prev, m_trace;
  logic [31:0] tq[$];

  function automatic int sat(input int v);
    return (v >= SATMAX) ? SATMAX : v + 1;
  endfunction

  function automatic logic [31:0] trace_lookup(input int idx);
    if (idx < tq.size()) return tq[tq.size() - 1 - idx];
    return 32'd0;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit act,
                            input logic [31:0] addr, input logic [31:0] v0);
    if (rst) begin
      m_started = 0; m_finished = 0;
      m_done = 0; m_pass = 0; m_fc = 0;
      m_cyc = 0; m_fetch = 0; m_redir = 0;
      m_prev = 0; m_trace = 0;
      tq.delete();
    end else if (en) begin
`ifdef RUN_MONITOR_TRACE_EN
      m_trace = trace_lookup(int'(trace_idx));
`endif
      if (!m_started) begin
        m_started = 1;
        if (addr == RV) begin
          m_prev = addr; m_fetch = 1;
        end else begin
          m_finished = 1; m_done = 1; m_fc = 3;
        end
      end else if (!m_finished) begin
        if (addr == HALT || !act) begin
          m_finished = 1; m_done = 1;
          m_pass = (v0 == expected_v0) ? 1 : 0;
          m_fc = m_pass ? 0 : 1;
        end else if (max_cycles != 0 && m_cyc + 1 == int'(max_cycles)) begin
          m_finished = 1; m_done = 1; m_fc = 2;
        end else begin
          m_cyc = sat(m_cyc);
          if (addr != m_prev) begin
            m_fetch = sat(m_fetch);
            if (addr != m_prev + 32'd4) begin
              m_redir = sat(m_redir);
              tq.push_back(addr);
              if (tq.size() > TDEPTH) void'(tq.pop_front());
            end
          end
          m_prev = addr;
        end
      end
    end
  endtask

  // Compare every output against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("done", {31'd0, done}, m_done);
      check("pass", {31'd0, pass}, m_pass);
      check("fail_code", {30'd0, fail_code}, m_fc);
      check("cycle_count", 32'(cycle_count), m_cyc);
      check("fetch_count", 32'(fetch_count), m_fetch);
      check("redirect_count", 32'(redirect_count), m_redir);
      check("trace_addr", trace_addr, m_trace);
    end
  end

  // Drive one cycle, let the model see the same inputs, return at negedge.
  task automatic step(input bit rst, input bit en, input bit act,
                      input logic [31:0] addr, input logic [31:0] v0);
    reset = rst; clk_enable = en; active = act;
    instr_address = addr; register_v0 = v0;
    @(posedge clk);
    model_edge(rst, en, act, addr, v0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
  endtask

  task automatic run(input logic [31:0] addr, input logic [31:0] v0);
    step(1'b0, 1'b1, 1'b1, addr, v0);
  endtask

  logic [31:0] pc;
  logic [31:0] bgez [5];

  initial begin
    bgez[0] = 32'hBFC0_0000; bgez[1] = 32'hBFC0_0008; bgez[2] = 32'hBFC0_000C;
    bgez[3] = 32'hBFC0_0010; bgez[4] = 32'hBFC0_0014;
    @(negedge clk);
    do_reset();
    cmp_on = 1'b1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_fetch", 32'(fetch_count), 32'd0);

    // BGEZ-style program, v0 correct.
    expected_v0 = 32'd2; max_cycles = '0;
    foreach (bgez[i]) run(bgez[i], 32'd2);
    check("bgez_done_before_halt", {31'd0, done}, 32'd0);
    run(HALT, 32'd2);
    check("bgez_done", {31'd0, done}, 32'd1);
    check("bgez_pass", {31'd0, pass}, 32'd1);
    check("bgez_fc", {30'd0, fail_code}, 32'd0);
    check("bgez_fetch", 32'(fetch_count), 32'd5);
    check("bgez_redir", 32'(redirect_count), 32'd1);
    check("bgez_cycles", 32'(cycle_count), 32'd4);

    // Same program, wrong v0.
    do_reset();
    foreach (bgez[i]) run(bgez[i], 32'd3);
    run(HALT, 32'd3);
    check("badv0_pass", {31'd0, pass}, 32'd0);
    check("badv0_fc", {30'd0, fail_code}, 32'd1);

    // Tight loop with timeout at 20.
    do_reset();
    max_cycles = CNT_W'(20);
    pc = RV;
    for (int i = 0; i < 40 && !done; i++) begin
      run(pc, 32'd0);
      pc = (pc == RV) ? RV + 32'd4 : RV;
    end
    check("timeout_fc", {30'd0, fail_code}, 32'd2);
    check("timeout_cycles", 32'(cycle_count), 32'd19);

    // Same loop with timeout disabled: never finishes, counters saturate.
    do_reset();
    max_cycles = '0;
    pc = RV;
    for (int i = 0; i < 200; i++) begin
      run(pc, 32'd0);
      pc = (pc == RV) ? RV + 32'd4 : RV;
    end
    check("notimeout_done", {31'd0, done}, 32'd0);
    check("sat_cycles", 32'(cycle_count), SATMAX);
    check("sat_fetch", 32'(fetch_count), SATMAX);

    // Bad start address.
    do_reset();
    run(RV + 32'd4, 32'd0);
    check("badstart_fc", {30'd0, fail_code}, 32'd3);
    check("badstart_done", {31'd0, done}, 32'd1);

    // Halt on the timeout edge: halt wins (pass and fail variants).
    for (int k = 0; k < 2; k++) begin
      do_reset();
      max_cycles = CNT_W'(3); expected_v0 = 32'd7;
      run(RV, 32'd7); run(RV + 32'd4, 32'd7); run(RV + 32'd8, 32'd7);
      run(HALT, (k == 0) ? 32'd7 : 32'd1);
      check("halt_wins_fc", {30'd0, fail_code}, (k == 0) ? 32'd0 : 32'd1);
    end

    // Stall then clock-enable gap.
    do_reset();
    max_cycles = '0;
    run(RV, 32'd0);
    repeat (3) run(RV + 32'd4, 32'd0);
    run(RV + 32'd8, 32'd0);
    repeat (5) step(1'b0, 1'b0, 1'b0, HALT, 32'd0);
    run(RV + 32'd12, 32'd0);
    check("stall_fetch", 32'(fetch_count), 32'd4);
    check("stall_redir", 32'(redirect_count), 32'd0);
    check("stall_cycles", 32'(cycle_count), 32'd5);
    check("stall_done", {31'd0, done}, 32'd0);
    do_reset();
    check("midrun_reset_cycles", 32'(cycle_count), 32'd0);
    check("midrun_reset_fetch", 32'(fetch_count), 32'd0);
    run(RV + 32'd4, 32'd0);
    check("after_reset_wait_start", {30'd0, fail_code}, 32'd3);

`ifdef RUN_MONITOR_TRACE_EN
    // Six redirects into a 4-deep trace: newest-first readback.
    do_reset();
    run(RV, 32'd0);
    for (int t = 1; t <= 6; t++) run(RV + 32'(t * 256), 32'd0);
    run(HALT, 32'd0);
    for (int i = 0; i < 4; i++) begin
      trace_idx = 2'(i);
      run(HALT, 32'd0);
      check("trace_entry", trace_addr, RV + 32'((6 - i) * 256));
    end
`endif

    // Randomized programs.
    for (int p = 0; p < 40; p++) begin
      do_reset();
      expected_v0 = $urandom_range(0, 3);
      max_cycles  = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 40));
      pc = ($urandom_range(0, 9) == 0) ? RV + 32'd4 : RV;
      for (int c = 0; c < 60; c++) begin
        trace_idx = 2'($urandom_range(0, 3));
        step(($urandom_range(0, 80) == 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 40) != 0), pc, $urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: pc = pc + 32'd4;
          6, 7:             pc = pc;
          8:                pc = RV + ($urandom_range(0, 63) << 2);
          default:          pc = ($urandom_range(0, 3) == 0) ? HALT : pc - 32'd8;
        endcase
      end
    end

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
